// File: rtl/keypad_event_fifo.sv
// Keypad event queue: synchronizes the column lines, debounces a press, decodes
// the scanner key code once per press and queues key values for a consumer.
module keypad_event_fifo #(
   parameter int DEBOUNCE_CYCLES = 256,
   parameter int RELEASE_CYCLES  = 64,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   input  logic [7:0] key_code,
   output logic [3:0] key_value,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overflow,
   output logic       code_err
);

   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int IW = $clog2(RELEASE_CYCLES + 1);
   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DEBOUNCE = 2'd1;
   localparam logic [1:0] S_HELD     = 2'd2;

   logic [3:0]    col_m, col_s;
   logic [IW-1:0] idle_cnt;
   logic [DW-1:0] deb_cnt;
   logic [1:0]    state;
   logic          active, quiet, accept, code_valid, push, pop, full;
   logic [1:0]    row_idx, col_idx;
   logic [3:0]    dec_value;
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   // Two-flop synchronizer; reset to the released (all-high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_m <= 4'hF;
         col_s <= 4'hF;
      end else begin
         col_m <= col;
         col_s <= col_m;
      end
   end

   assign active = (col_s != 4'hF);
   assign quiet  = (idle_cnt == IW'(RELEASE_CYCLES));

   // Measures the gap since a column was last seen low; spans a full scanner sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          idle_cnt <= IW'(RELEASE_CYCLES);
      else if (active)  idle_cnt <= '0;
      else if (!quiet)  idle_cnt <= idle_cnt + 1'b1;
   end

   assign accept = (state == S_DEBOUNCE) && !quiet && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         deb_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (active) begin
                  state   <= S_DEBOUNCE;
                  deb_cnt <= '0;
               end
            end
            S_DEBOUNCE: begin
               deb_cnt <= deb_cnt + 1'b1;
               if (quiet)       state <= S_IDLE;
               else if (accept) state <= S_HELD;
            end
            S_HELD: begin
               if (quiet) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign key_held = (state != S_IDLE);

   always_comb begin
      code_valid = $onehot(key_code[7:4]) && $onehot(key_code[3:0]);
      case (key_code[7:4])
         4'b1000: row_idx = 2'd0;
         4'b0100: row_idx = 2'd1;
         4'b0010: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
      case (key_code[3:0])
         4'b1000: col_idx = 2'd0;
         4'b0100: col_idx = 2'd1;
         4'b0010: col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase
      // Row-major keypad layout: * and # encode as 0xE and 0xF.
      case ({row_idx, col_idx})
         4'd0:    dec_value = 4'h1;
         4'd1:    dec_value = 4'h2;
         4'd2:    dec_value = 4'h3;
         4'd3:    dec_value = 4'hA;
         4'd4:    dec_value = 4'h4;
         4'd5:    dec_value = 4'h5;
         4'd6:    dec_value = 4'h6;
         4'd7:    dec_value = 4'hB;
         4'd8:    dec_value = 4'h7;
         4'd9:    dec_value = 4'h8;
         4'd10:   dec_value = 4'h9;
         4'd11:   dec_value = 4'hC;
         4'd12:   dec_value = 4'hE;
         4'd13:   dec_value = 4'h0;
         4'd14:   dec_value = 4'hF;
         default: dec_value = 4'hD;
      endcase
   end

   // Handshake: the head entry transfers on any clk edge where key_valid and
   // key_ready are both high; key_value is stable while key_valid is high.
   assign full      = (count == CW'(FIFO_DEPTH));
   assign key_valid = (count != '0);
   assign key_value = mem[rd_ptr];
   assign pop       = key_valid && key_ready;
   assign push      = accept && code_valid && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         code_err <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec_value;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         if (accept && code_valid && full && !pop) overflow <= 1'b1;
         if (accept && !code_valid)                code_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Randomized bench for keypad_event_fifo: presses are scheduled against a
// queue model of accepted key values, checked on every consumer handshake.
module tb_keypad_event_fifo;

   localparam int D     = 256;
   localparam int R     = 64;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] col = 4'hF;
   logic [7:0] key_code = 8'h00;
   logic [3:0] key_value;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic       key_held;
   logic       overflow;
   logic       code_err;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];
   bit         exp_overflow = 1'b0;
   bit         exp_code_err = 1'b0;
   bit         mon_en       = 1'b0;
   bit         rand_ready   = 1'b0;

   logic [3:0] tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   keypad_event_fifo #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .col(col), .key_code(key_code),
      .key_value(key_value), .key_valid(key_valid), .key_ready(key_ready),
      .key_held(key_held), .overflow(overflow), .code_err(code_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: flags and queue occupancy every cycle, values on every transfer.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         checks++;
         if (key_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL key_valid: got %b expected %b", key_valid, exp_q.size() != 0);
         end
         checks++;
         if (overflow !== exp_overflow) begin
            failures++;
            $display("FAIL overflow: got %b expected %b", overflow, exp_overflow);
         end
         checks++;
         if (code_err !== exp_code_err) begin
            failures++;
            $display("FAIL code_err: got %b expected %b", code_err, exp_code_err);
         end
         if (key_valid === 1'b1 && key_ready === 1'b1 && exp_q.size() != 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (key_value !== e) begin
               failures++;
               $display("FAIL pop_value: got %h expected %h", key_value, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pick_key(output logic [7:0] code, output logic [3:0] val, output int c);
      int r;
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      code = (8'h80 >> r) | (8'h08 >> c);
      val  = tbl[r*4 + c];
   endtask

   // Scanner-like press: column c low for 11 of every 44 cycles.
   task automatic press(input logic [7:0] code, input logic [3:0] val, input bit ok,
                        input int c, input int ncyc, input bit ready_acc, output int li);
      li = -1;
      key_code = code;
      for (int i = 0; i < ncyc; i++) begin
         if ((i % 44) < 11) begin
            col = ~(4'b0001 << c);
            li  = i;
         end else begin
            col = 4'hF;
         end
         if (rand_ready) key_ready = 1'($urandom_range(0, 1));
         else if (ready_acc) key_ready = (i == D + 2);
         tick();
         if (i + 1 == 2) begin
            checks++;
            if (key_held !== 1'b0) begin
               failures++;
               $display("FAIL held_early: got %b expected 0", key_held);
            end
         end
         if (i + 1 == ncyc) begin
            checks++;
            if (key_held !== 1'b1) begin
               failures++;
               $display("FAIL held_during: got %b expected 1", key_held);
            end
         end
         if (i + 1 == D + 3) begin
            if (!ok) exp_code_err = 1'b1;
            else if (exp_q.size() == DEPTH) exp_overflow = 1'b1;
            else exp_q.push_back(val);
         end
      end
      col = 4'hF;
      if (ready_acc && !rand_ready) key_ready = 1'b0;
   endtask

   task automatic release_wait(input int li, input int ncyc);
      int dropped;
      dropped = -1;
      for (int e = ncyc + 1; e <= li + 200; e++) begin
         if (rand_ready) key_ready = 1'($urandom_range(0, 1));
         tick();
         if (key_held === 1'b0) begin
            dropped = e;
            break;
         end
      end
      checks++;
      if (dropped != li + R + 4) begin
         failures++;
         $display("FAIL release_time: got edge %0d expected %0d", dropped, li + R + 4);
      end
      repeat ($urandom_range(1, 20)) tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      key_ready = 1'b1;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      key_ready = 1'b0;
      tick();
      checks++;
      if (key_valid !== 1'b0 || n >= 20) begin
         failures++;
         $display("FAIL drain: key_valid %b after %0d cycles, expected empty", key_valid, n);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({key_value, key_valid, key_held, overflow, code_err} !== 8'h00) begin
         failures++;
         $display("FAIL %s: got value=%h valid=%b held=%b ovf=%b err=%b expected all 0",
                  name, key_value, key_valid, key_held, overflow, code_err);
      end
   endtask

   task automatic random_press(input bit ready_acc);
      logic [7:0] code;
      logic [3:0] val;
      int c, li, n;
      pick_key(code, val, c);
      n = $urandom_range(D + 10, D + 300);
      press(code, val, 1'b1, c, n, ready_acc, li);
      release_wait(li, n);
   endtask

   task automatic test_reset();
      #1;
      check_all_zero("reset_async");
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_all_zero("reset_released");
      mon_en = 1'b1;
   endtask

   task automatic test_press_5();
      int li;
      press(8'h44, 4'h5, 1'b1, 1, 1000, 1'b0, li);
      release_wait(li, 1000);
      checks++;
      if (key_valid !== 1'b1 || key_value !== 4'h5) begin
         failures++;
         $display("FAIL press_5: got valid=%b value=%h expected 1/5", key_valid, key_value);
      end
      drain();
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 3; k++) begin
         int li, n;
         n = $urandom_range(3, 20);
         press(8'h44, 4'h5, 1'b1, 1, n, 1'b0, li);
         release_wait(li, n);
      end
      checks++;
      if (key_valid !== 1'b0) begin
         failures++;
         $display("FAIL bounce_event: got key_valid %b expected 0", key_valid);
      end
   endtask

   task automatic test_repeat();
      for (int k = 0; k < 2; k++) begin
         int li, n;
         n = $urandom_range(D + 10, D + 300);
         press(8'h12, 4'hF, 1'b1, 2, n, 1'b0, li);
         release_wait(li, n);
      end
      checks++;
      if (key_valid !== 1'b1 || key_value !== 4'hF || exp_q.size() != 2) begin
         failures++;
         $display("FAIL repeat: got valid=%b value=%h queued=%0d expected 1/f/2",
                  key_valid, key_value, exp_q.size());
      end
      drain();
   endtask

   task automatic test_full_simul();
      for (int k = 0; k < DEPTH; k++) random_press(1'b0);
      random_press(1'b1);
      checks++;
      if (overflow !== 1'b0 || exp_q.size() != DEPTH) begin
         failures++;
         $display("FAIL full_simul: got overflow=%b queued=%0d expected 0/%0d",
                  overflow, exp_q.size(), DEPTH);
      end
      drain();
   endtask

   task automatic test_overflow();
      for (int k = 0; k < DEPTH + 1; k++) random_press(1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow_set: got %b expected 1", overflow);
      end
      drain();
   endtask

   task automatic test_code_err();
      int li, n;
      n = D + 50;
      press(8'h66, 4'h0, 1'b0, 1, n, 1'b0, li);
      release_wait(li, n);
      checks++;
      if (code_err !== 1'b1 || key_valid !== 1'b0) begin
         failures++;
         $display("FAIL code_err_press: got err=%b valid=%b expected 1/0", code_err, key_valid);
      end
   endtask

   task automatic test_random_ready();
      rand_ready = 1'b1;
      for (int k = 0; k < 6; k++) random_press(1'b0);
      rand_ready = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid_debounce();
      logic [7:0] code;
      logic [3:0] val;
      int c;
      pick_key(code, val, c);
      key_code = code;
      col = ~(4'b0001 << c);
      repeat (50) tick();
      checks++;
      if (key_held !== 1'b1) begin
         failures++;
         $display("FAIL mid_debounce_held: got %b expected 1", key_held);
      end
      rst = 1'b1;
      col = 4'hF;
      exp_q.delete();
      exp_overflow = 1'b0;
      exp_code_err = 1'b0;
      #1;
      check_all_zero("reset_mid_debounce");
      tick();
      tick();
      rst = 1'b0;
      repeat (D + 100) tick();
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_event: got valid=%b held=%b expected 0/0", key_valid, key_held);
      end
   endtask

   initial begin
      test_reset();
      test_press_5();
      test_bounce();
      test_repeat();
      test_full_simul();
      test_overflow();
      test_code_err();
      test_random_ready();
      test_reset_mid_debounce();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
